// File: rtl/muldiv_pkg.sv
// Shared op encodings, controller states and operand-signedness helpers for the M-extension unit.
package muldiv_pkg;

    localparam logic [2:0] MUL_OP    = 3'b000;
    localparam logic [2:0] MULH_OP   = 3'b001;
    localparam logic [2:0] MULHSU_OP = 3'b010;
    localparam logic [2:0] MULHU_OP  = 3'b011;
    localparam logic [2:0] DIV_OP    = 3'b100;
    localparam logic [2:0] DIVU_OP   = 3'b101;
    localparam logic [2:0] REM_OP    = 3'b110;
    localparam logic [2:0] REMU_OP   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == MULH_OP) || (op == MULHSU_OP) || (op == DIV_OP) || (op == REM_OP);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == MULH_OP) || (op == DIV_OP) || (op == REM_OP);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 step: shift-add multiply on {hi,lo}, or restoring divide with hi=remainder, lo=quotient.
// Purely combinational, no flow control; the sequencer decides when a step is committed.
module muldiv_step #(
    parameter int XLEN = 64
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opb,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);
    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, opb};
        if (is_div) begin
            // diff MSB set means the trial subtraction went negative: restore
            if (!diff[XLEN]) begin
                hi_next = diff[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = shifted[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_next = sum[XLEN:1];
            lo_next = {sum[0], lo[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RISC-V M-extension multiply/divide with its own controller beside the EX-stage ALU.
// Latency XLEN+2 cycles (1 for divide-by-zero/overflow); holds stall while working, flush aborts.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_next;
    logic [CW-1:0]     count;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   hi_q, lo_q, opb_q, hi_next, lo_next;
    logic              accept, a_neg, b_neg, div_zero, div_ovf, special;
    logic [XLEN-1:0]   abs_a, abs_b, special_val, quot_fix, rem_fix, fix_val;
    logic [2*XLEN-1:0] prod_fix;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (is_div(op_q)),
        .hi      (hi_q),
        .lo      (lo_q),
        .opb     (opb_q),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_next = special ? S_DONE : S_CALC;
                S_CALC:  if (count == '0) state_next = S_FIX;
                S_FIX:   state_next = S_DONE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        accept = (state == S_IDLE) && start && !flush && !reset;
        busy   = (state != S_IDLE);
        stall  = accept || (state == S_CALC) || (state == S_FIX);
        done   = (state == S_DONE);
    end

    always_comb begin
        a_neg    = is_signed_a(op) && rs1[XLEN-1];
        b_neg    = is_signed_b(op) && rs2[XLEN-1];
        abs_a    = a_neg ? -rs1 : rs1;
        abs_b    = b_neg ? -rs2 : rs2;
        div_zero = is_div(op) && (rs2 == '0);
        div_ovf  = is_div(op) && is_signed_b(op) && (rs1 == MIN_NEG) && (rs2 == '1);
        special  = div_zero || div_ovf;
        // op[1] separates REM/REMU from DIV/DIVU within the divide group
        if (div_zero) special_val = op[1] ? rs1 : '1;
        else          special_val = op[1] ? '0  : rs1;
    end

    always_comb begin
        prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quot_fix = neg_q ? -lo_q : lo_q;
        rem_fix  = neg_q ? -hi_q : hi_q;
        case (op_q)
            MUL_OP:                       fix_val = prod_fix[XLEN-1:0];
            MULH_OP, MULHSU_OP, MULHU_OP: fix_val = prod_fix[2*XLEN-1:XLEN];
            DIV_OP, DIVU_OP:              fix_val = quot_fix;
            default:                      fix_val = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            op_q   <= MUL_OP;
            neg_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            opb_q  <= '0;
            result <= '0;
        end else if (accept) begin
            op_q  <= op;
            count <= CW'(XLEN - 1);
            hi_q  <= '0;
            // remainder follows the dividend; everything else follows the operand sign product
            neg_q <= (is_div(op) && op[1]) ? a_neg : (a_neg ^ b_neg);
            if (is_div(op)) begin
                lo_q  <= abs_a;
                opb_q <= abs_b;
            end else begin
                lo_q  <= abs_b;
                opb_q <= abs_a;
            end
            if (special) result <= special_val;
        end else if (!flush && state == S_CALC) begin
            hi_q  <= hi_next;
            lo_q  <= lo_next;
            count <= count - CW'(1);
        end else if (!flush && state == S_FIX) begin
            result <= fix_val;
        end
    end

endmodule
